prio_req_encoder: RTL and testbench
===================================

# prio_req_encoder

Parametrised, registered priority request encoder: the sequential successor of the team's 8:3 combinational priority encoder with enable. It collects one-cycle request pulses from N sources into a pending vector, masks them, and presents the highest-priority pending index on a valid/ready handshake, clearing each request as it is accepted. It sits between request sources (interrupt lines, channel-ready flags) and a single serving consumer.

## Interface
- `N`, default 8: number of request inputs; legal range 2..64.
- `PRIORITY_MSB`, default 1: 1 means bit N-1 is highest priority; 0 means bit 0 is highest.
- `W`: localparam, not overridable, equal to $clog2(N); output index width.

Ports:
- `clk`, in, 1: single clock; all state changes on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `enable`, in, 1: block enable.
- `din`, in, N: request pulses, sampled every enabled cycle.
- `mask`, in, N: 1 blocks that request from selection; the pending bit is kept.
- `ready`, in, 1: consumer accepts `dout` when `valid && ready`.
- `dout`, out, W: registered index of the presented request.
- `valid`, out, 1: `dout` holds a request.
- `pending`, out, N: registered pending vector.

## Operation
- Registers: `pending[N-1:0]`, `dout`, `valid`. Two-state FSM encoded by `valid`: IDLE (0) and PRESENT (1).
- acc = `pending | din` when `enable` is 1; acc = `pending` when `enable` is 0, so `din` is ignored while disabled.
- hs = `valid && ready && enable`. clr = one-hot(`dout`) when hs, else 0.
- `pending_next = (acc & ~clr) | (din & clr & {N{enable}})`. A new pulse on the bit being cleared wins, and the bit stays pending.
- cand = `pending_next & ~mask`. sel is the highest-priority set bit of cand per `PRIORITY_MSB`. found = |cand.
- IDLE: if `enable && found`, load `dout <= sel`, `valid <= 1`, and go to PRESENT. Otherwise stay in IDLE with `dout` unchanged.
- PRESENT with `!ready`: hold `dout` and `valid` stable. There is no preemption by higher-priority arrivals or by `mask` changes.
- PRESENT with hs: clear the served bit. If found, load the new sel and stay in PRESENT (back-to-back, one per cycle). Otherwise go to IDLE with `valid <= 0`.
- `enable` = 0 in any state: `valid <= 0`, `dout <= 0`, and the state goes to IDLE. `pending` is retained with no capture and no clear.
- Masked pending bits persist until unmasked and served.
- A request already pending that pulses again is not counted twice.

## Timing
- Reset (async assert, synchronous release): `pending` = 0, `dout` = 0, `valid` = 0, state = IDLE.
- Latency: a `din` pulse in cycle t (IDLE, enabled, unmasked, highest priority) gives `valid` = 1 and the index on `dout` in cycle t+1.
- Throughput: one accepted request per cycle with `ready` held high.
- Reset asserted mid-handshake drops `valid` immediately and loses all pending requests.
- `enable` deassertion takes effect at the next edge. Re-enabling presents the highest pending request one cycle later.
- All outputs are driven directly from flops; there are no combinational input-to-output paths.

## Structure
- Shared package `prio_enc_pkg`: function `prio_find(vec, msb_first)` returning index and found flag, plus an index-to-one-hot helper. Both are reusable by the combinational 8:3 encoder's successors.
- One sub-module, `prio_find_comb`: combinational N-to-W priority search with a found output, parameterised by `N` and `PRIORITY_MSB`.
- The top level holds only the registers and the handshake logic.

## Test plan
All scenarios use N=8 and PRIORITY_MSB=1.
- **Reset:** hold `rst_n` = 0 with random `din` → `dout` = 0, `valid` = 0, `pending` = 0. Assert `rst_n` low mid-PRESENT → `valid` drops with no clock edge.
- **Simultaneous pulses:** `din` = 8'b0010_0100 for one cycle, `ready` = 1 → `dout` = 5, then 2 on consecutive cycles, then `valid` = 0 and `pending` = 0.
- **Hold, no preemption:** `din` = 8'b0000_0010, `ready` = 0; next cycle `din` = 8'b1000_0000 → `dout` stays 1 until `ready`. After that `dout` = 7.
- **Mask:** `mask` = 8'hF0, `din` = 8'h90 → `valid` stays 0 and `pending` = 8'h90. Clear `mask` → `dout` = 7, then 4.
- **Re-request during accept:** `dout` = 3 accepted while `din[3]` = 1 in the same cycle → `pending[3]` stays 1 and `dout` = 3 is presented again next cycle.
- **Enable:** `enable` = 0 with `din` = 8'hFF → `pending` unchanged and `valid` = 0. Drop `enable` while PRESENT → `valid` = 0, `dout` = 0, and the served bit is still pending.

Source files
------------

// File: rtl/prio_enc_pkg.sv
// Shared priority-search helpers for the priority encoder family.
// Searches run over a fixed 64-bit vector; narrower callers zero-extend.
package prio_enc_pkg;

  localparam int MAX_N = 64;
  localparam int MAX_W = 6;

  typedef enum logic {IDLE = 1'b0, PRESENT = 1'b1} enc_state_t;

  typedef struct packed {
    logic             found;
    logic [MAX_W-1:0] idx;
  } find_t;

  // Last hit in scan order wins, so the scan runs toward the priority end.
  function automatic find_t prio_find(input logic [MAX_N-1:0] vec, input logic msb_first);
    find_t r;
    int    b;
    r = '0;
    for (int i = 0; i < MAX_N; i++) begin
      b = msb_first ? i : (MAX_N - 1 - i);
      if (vec[b]) begin
        r.found = 1'b1;
        r.idx   = b[MAX_W-1:0];
      end
    end
    return r;
  endfunction

  function automatic logic [MAX_N-1:0] idx2onehot(input logic [MAX_W-1:0] idx);
    logic [MAX_N-1:0] one;
    one = {{(MAX_N-1){1'b0}}, 1'b1};
    return one << idx;
  endfunction

endpackage

// File: rtl/prio_find_comb.sv
// Combinational N-to-W priority search with found flag.
module prio_find_comb
  import prio_enc_pkg::*;
#(
  parameter int N            = 8,
  parameter int PRIORITY_MSB = 1,
  localparam int W           = $clog2(N)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         found
);

  find_t r;

  always_comb begin
    r     = prio_find(MAX_N'(vec), PRIORITY_MSB != 0);
    idx   = W'(r.idx);
    found = r.found;
  end

endmodule

// File: rtl/prio_req_encoder.sv
// Registered priority request encoder: captures request pulses into a pending
// vector and presents the highest-priority unmasked one on valid/ready.
module prio_req_encoder
  import prio_enc_pkg::*;
#(
  parameter int N            = 8,
  parameter int PRIORITY_MSB = 1,
  localparam int W           = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  input  logic [N-1:0] din,
  input  logic [N-1:0] mask,
  input  logic         ready,
  output logic [W-1:0] dout,
  output logic         valid,
  output logic [N-1:0] pending
);

  enc_state_t   st;
  logic [N-1:0] acc, clr, pnd_nxt, cand;
  logic [W-1:0] sel;
  logic         found, hs;

  always_comb begin
    acc     = enable ? (pending | din) : pending;
    hs      = (st == PRESENT) && ready && enable;
    clr     = hs ? N'(idx2onehot(MAX_W'(dout))) : '0;
    // A fresh pulse on the bit being served keeps it pending.
    pnd_nxt = (acc & ~clr) | (din & clr & {N{enable}});
    cand    = pnd_nxt & ~mask;
  end

  prio_find_comb #(.N(N), .PRIORITY_MSB(PRIORITY_MSB)) u_find (
    .vec   (cand),
    .idx   (sel),
    .found (found)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      dout    <= '0;
      st      <= IDLE;
    end else begin
      pending <= pnd_nxt;
      if (!enable) begin
        st   <= IDLE;
        dout <= '0;
      end else begin
        case (st)
          IDLE:
            if (found) begin
              dout <= sel;
              st   <= PRESENT;
            end
          PRESENT:
            if (ready) begin
              if (found) dout <= sel;
              else       st   <= IDLE;
            end
        endcase
      end
    end
  end

  assign valid = (st == PRESENT);

endmodule

// File: tb/tb_prio_req_encoder.sv
// Directed plus random bench for prio_req_encoder (N=8, MSB-first priority).
module tb_prio_req_encoder;

  logic       clk = 1'b0;
  logic       rst_n, enable, ready;
  logic [7:0] din, mask;
  logic [2:0] dout;
  logic       valid;
  logic [7:0] pending;

  int errors = 0;
  int checks = 0;

  // reference state
  logic [7:0] m_pend;
  logic [2:0] m_dout;
  logic       m_vld;

  always #5 clk = ~clk;

  prio_req_encoder #(.N(8), .PRIORITY_MSB(1)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .din(din), .mask(mask),
    .ready(ready), .dout(dout), .valid(valid), .pending(pending)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Next state computed from the request rules: requests accumulate, the
  // accepted one is removed unless re-requested, then the highest unmasked
  // pending index is offered whenever the output slot is free.
  task automatic model_next(output logic [7:0] np, output logic [2:0] nd, output logic nv);
    logic       accept, f;
    logic [2:0] best;
    np = m_pend;
    nd = m_dout;
    nv = m_vld;
    accept = m_vld && ready && enable;
    if (enable) np = np | din;
    if (accept && !din[m_dout]) np[m_dout] = 1'b0;
    f = 1'b0;
    best = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (!f && np[i] && !mask[i]) begin
        f = 1'b1;
        best = 3'(i);
      end
    if (!enable) begin
      nv = 1'b0;
      nd = 3'd0;
    end else if (!m_vld || ready) begin
      if (f) begin
        nv = 1'b1;
        nd = best;
      end else nv = 1'b0;
    end
  endtask

  task automatic step();
    logic [7:0] np;
    logic [2:0] nd;
    logic       nv;
    model_next(np, nd, nv);
    @(posedge clk);
    #1;
    if (!rst_n) begin
      m_pend = '0; m_dout = '0; m_vld = 1'b0;
    end else begin
      m_pend = np; m_dout = nd; m_vld = nv;
    end
    chk("model_valid", valid, m_vld);
    chk("model_pending", pending, m_pend);
    if (m_vld) chk("model_dout", dout, m_dout);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b1; ready = 1'b0; din = '0; mask = '0;
    m_pend = '0; m_dout = '0; m_vld = 1'b0;

    // reset with random requests
    for (int i = 0; i < 4; i++) begin
      din = 8'($urandom);
      step();
      chk("rst_dout", dout, 3'd0);
      chk("rst_valid", valid, 1'b0);
      chk("rst_pending", pending, 8'h00);
    end
    rst_n = 1'b1; din = '0;
    step();

    // simultaneous pulses
    ready = 1'b1; din = 8'b0010_0100;
    step(); chk("sim_first", dout, 3'd5); chk("sim_first_v", valid, 1'b1);
    din = '0;
    step(); chk("sim_second", dout, 3'd2); chk("sim_second_v", valid, 1'b1);
    step(); chk("sim_done_v", valid, 1'b0); chk("sim_done_p", pending, 8'h00);

    // hold without preemption
    ready = 1'b0; din = 8'b0000_0010;
    step(); chk("hold_a", dout, 3'd1);
    din = 8'b1000_0000;
    step(); chk("hold_b", dout, 3'd1);
    din = '0;
    step(); chk("hold_c", dout, 3'd1); chk("hold_c_v", valid, 1'b1);
    ready = 1'b1;
    step(); chk("hold_next", dout, 3'd7);
    step(); chk("hold_done", valid, 1'b0);

    // mask
    mask = 8'hF0; din = 8'h90;
    step(); chk("mask_v", valid, 1'b0); chk("mask_p", pending, 8'h90);
    din = '0;
    step(); chk("mask_held_v", valid, 1'b0);
    mask = '0;
    step(); chk("unmask_a", dout, 3'd7);
    step(); chk("unmask_b", dout, 3'd4); chk("unmask_b_p", pending, 8'h10);
    step(); chk("unmask_done", valid, 1'b0);

    // re-request on the accepted bit
    din = 8'h08;
    step(); chk("rereq_a", dout, 3'd3);
    step(); chk("rereq_p", pending[3], 1'b1); chk("rereq_b", dout, 3'd3);
    chk("rereq_bv", valid, 1'b1);
    din = '0;
    step(); chk("rereq_done", valid, 1'b0);

    // enable handling
    ready = 1'b0; din = 8'h01;
    step(); chk("en_pres", valid, 1'b1);
    enable = 1'b0; ready = 1'b1; din = 8'hFF;
    step(); chk("en_off_v", valid, 1'b0); chk("en_off_d", dout, 3'd0);
    chk("en_off_p", pending, 8'h01);
    din = 8'hFF;
    step(); chk("en_off2_p", pending, 8'h01);
    enable = 1'b1; din = '0;
    step(); chk("reen_v", valid, 1'b1); chk("reen_d", dout, 3'd0);
    step(); chk("reen_done", valid, 1'b0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      din    = 8'($urandom) & 8'($urandom) & 8'($urandom);
      mask   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      ready  = ($urandom_range(0, 3) != 0);
      enable = ($urandom_range(0, 9) != 0);
      step();
    end

    // async reset mid-PRESENT
    enable = 1'b1; ready = 1'b0; mask = '0; din = 8'h42;
    step(); chk("arst_pre_v", valid, 1'b1);
    din = '0;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", valid, 1'b0);
    chk("arst_pending", pending, 8'h00);
    m_pend = '0; m_dout = '0; m_vld = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
